// File: rtl/bus_pkg.sv
// Shared bus definitions: source indices, the "no owner" select code and arbiter FSM states.
package bus_pkg;

   localparam int unsigned SEL_W   = 5;
   localparam int unsigned GRANT_W = 32;

   localparam logic [SEL_W-1:0] SRC_R0     = 5'd0;
   localparam logic [SEL_W-1:0] SRC_R1     = 5'd1;
   localparam logic [SEL_W-1:0] SRC_R2     = 5'd2;
   localparam logic [SEL_W-1:0] SRC_R3     = 5'd3;
   localparam logic [SEL_W-1:0] SRC_R4     = 5'd4;
   localparam logic [SEL_W-1:0] SRC_R5     = 5'd5;
   localparam logic [SEL_W-1:0] SRC_R6     = 5'd6;
   localparam logic [SEL_W-1:0] SRC_R7     = 5'd7;
   localparam logic [SEL_W-1:0] SRC_R8     = 5'd8;
   localparam logic [SEL_W-1:0] SRC_R9     = 5'd9;
   localparam logic [SEL_W-1:0] SRC_R10    = 5'd10;
   localparam logic [SEL_W-1:0] SRC_R11    = 5'd11;
   localparam logic [SEL_W-1:0] SRC_R12    = 5'd12;
   localparam logic [SEL_W-1:0] SRC_R13    = 5'd13;
   localparam logic [SEL_W-1:0] SRC_R14    = 5'd14;
   localparam logic [SEL_W-1:0] SRC_R15    = 5'd15;
   localparam logic [SEL_W-1:0] SRC_HI     = 5'd16;
   localparam logic [SEL_W-1:0] SRC_LO     = 5'd17;
   localparam logic [SEL_W-1:0] SRC_ZHI    = 5'd18;
   localparam logic [SEL_W-1:0] SRC_ZLO    = 5'd19;
   localparam logic [SEL_W-1:0] SRC_PC     = 5'd20;
   localparam logic [SEL_W-1:0] SRC_MDR    = 5'd21;
   localparam logic [SEL_W-1:0] SRC_INPORT = 5'd22;
   localparam logic [SEL_W-1:0] SRC_CSIGN  = 5'd23;

   localparam logic [SEL_W-1:0] SEL_NONE   = 5'b11111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_e;

endpackage

// File: rtl/bus_grant_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or above ptr_i, wrapping at N_SRC.
module rr_pick
   import bus_pkg::*;
#(
   parameter int unsigned N_SRC = 24
)
(
   input  logic [N_SRC-1:0] req_i,
   input  logic [SEL_W-1:0] ptr_i,
   output logic [SEL_W-1:0] win_o,
   output logic             found_o
);

   logic [N_SRC-1:0] rot;
   logic [SEL_W:0]   idx;

   // Rotate so ptr lands at bit 0, take the lowest set bit, then map back to a source index.
   always_comb begin
      rot     = N_SRC'({req_i, req_i} >> ptr_i);
      found_o = 1'b0;
      win_o   = SEL_NONE;
      idx     = '0;
      for (int unsigned j = 0; j < N_SRC; j++) begin
         if (!found_o && rot[j]) begin
            found_o = 1'b1;
            idx     = (SEL_W+1)'(ptr_i) + (SEL_W+1)'(j);
            if (idx >= (SEL_W+1)'(N_SRC)) begin
               idx = idx - (SEL_W+1)'(N_SRC);
            end
            win_o = idx[SEL_W-1:0];
         end
      end
   end

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin owner arbiter for the internal CPU bus with a mandatory turnaround cycle between owners.
// Optional owner watchdog enabled by defining BUS_GRANT_TIMEOUT_EN.
module bus_grant_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned N_SRC    = 24,
   parameter int unsigned MAX_HOLD = 16
)
(
   input  logic               clk,
   input  logic               clr,
   input  logic [N_SRC-1:0]   req,
   input  logic               release_i,
   output logic [GRANT_W-1:0] grant,
   output logic [SEL_W-1:0]   sel,
   output logic               busy,
   output logic               timeout
);

   if (N_SRC == 0 || N_SRC > 31 || MAX_HOLD < 2) begin : g_bad_cfg
      $error("bus_grant_arbiter: unsupported N_SRC or MAX_HOLD");
   end

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [GRANT_W-1:0] grant_q, grant_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               busy_q, busy_d;
   logic [SEL_W-1:0]   win;
   logic               found;
   logic               owner_req;
   logic               revoke;

`ifdef BUS_GRANT_TIMEOUT_EN
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              timeout_q, timeout_d;
`endif

   rr_pick #(.N_SRC(N_SRC)) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .win_o   (win),
      .found_o (found)
   );

   assign owner_req = |(grant_q & GRANT_W'(req));

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         sel_q   <= SEL_NONE;
         busy_q  <= 1'b0;
`ifdef BUS_GRANT_TIMEOUT_EN
         hold_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
`ifdef BUS_GRANT_TIMEOUT_EN
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   // Next state: IDLE loads the picker's winner, OWN holds until release, request drop or watchdog.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      revoke  = 1'b0;
`ifdef BUS_GRANT_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d = ST_OWN;
               grant_d = GRANT_W'(1'b1) << win;
               sel_d   = win;
               busy_d  = 1'b1;
               ptr_d   = (win == SEL_W'(N_SRC - 1)) ? '0 : win + SEL_W'(1);
`ifdef BUS_GRANT_TIMEOUT_EN
               hold_d  = '0;
`endif
            end
         end
         ST_OWN: begin
            if (release_i || !owner_req) begin
               revoke = 1'b1;
            end
`ifdef BUS_GRANT_TIMEOUT_EN
            else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
               revoke    = 1'b1;
               timeout_d = 1'b1;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
`endif
            if (revoke) begin
               state_d = ST_IDLE;
               grant_d = '0;
               sel_d   = SEL_NONE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign grant = grant_q;
   assign sel   = sel_q;
   assign busy  = busy_q;
`ifdef BUS_GRANT_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule
